// File: rtl/aes_pkg.sv
// AES shared types and byte-level transforms.
// Byte 0 of a block sits in bits [127:120]; byte i = column i/4, row i%4.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_st_t;
  typedef logic [127:0] aes_block_t;
  localparam int NB = 4;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // inverse as a^254 (product of a^(2^i), i=1..7), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] v;
    t = a;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      v = gmul(v, t);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t b);
    aes_block_t o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(b[127-8*i -: 8]);
    return o;
  endfunction

  function automatic aes_block_t shift_rows(input aes_block_t b);
    aes_block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = b[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t b);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_final_round.sv
// Last AES round: no MixColumns.
module aes_final_round
  import aes_pkg::*;
(
  input  aes_block_t blk,
  input  aes_block_t rk,
  output aes_block_t res
);

  assign res = shift_rows(sub_bytes(blk)) ^ rk;

endmodule

// File: rtl/encrypt_round.sv
// One full AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module encrypt_round
  import aes_pkg::*;
(
  input  aes_block_t blk,
  input  aes_block_t rk,
  output aes_block_t res
);

  assign res = mix_columns(shift_rows(sub_bytes(blk))) ^ rk;

endmodule

// File: rtl/key_expansion.sv
// Combinational AES key schedule for NK = 4/6/8.
// Round key 0 occupies the MSBs of fullkeys.
module key_expansion
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = nr_of(NK)
) (
  input  logic [32*NK-1:0]      key,
  output logic [128*(NR+1)-1:0] fullkeys
);

  localparam int NW = NB * (NR + 1);

  always_comb begin
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    t  = '0;
    rc = 8'h01;
    for (int i = 0; i < NK; i++)
      w[i] = key[32*(NK-1-i) +: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    fullkeys = '0;
    for (int i = 0; i < NW; i++)
      fullkeys[128*(NR+1)-32*(i+1) +: 32] = w[i];
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryptor, one round per clock, NK = 4/6/8.
// Handshaked input and output; DONE can accept the next block directly.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter  int NK    = 4,
  localparam int NR    = nr_of(NK),
  localparam int KEY_W = 32 * NK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy
);

  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] LAST = RW'(NR);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_iter_core: NK must be 4, 6 or 8");
  end

  aes_st_t                st, st_nxt;
  logic [RW-1:0]          rnd;
  aes_block_t             data_q, blk, rk, mid, fin;
  logic [KEY_W-1:0]       key_q;
  logic [128*(NR+1)-1:0]  fullkeys;
  logic                   accept;

  key_expansion #(.NK(NK), .NR(NR)) u_kexp (
    .key      (key_q),
    .fullkeys (fullkeys)
  );

  encrypt_round u_round (
    .blk (blk),
    .rk  (rk),
    .res (mid)
  );

  aes_final_round u_final (
    .blk (blk),
    .rk  (rk),
    .res (fin)
  );

  always_comb begin
    rk = '0;
    for (int r = 0; r <= NR; r++)
      if (rnd == RW'(r)) rk = fullkeys[128*(NR-r) +: 128];
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (st)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) st_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd == LAST) st_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !rst;
        if (out_ready) st_nxt = in_valid ? ROUND : IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd    <= '0;
      blk    <= '0;
      data_q <= '0;
      key_q  <= '0;
    end else if (accept) begin
      data_q <= in_data;
      key_q  <= in_key;
      rnd    <= '0;
    end else if (st == ROUND) begin
      rnd <= (rnd == LAST) ? '0 : rnd + RW'(1);
      unique case (1'b1)
        rnd == '0:   blk <= data_q ^ rk;
        rnd == LAST: blk <= fin;
        default:     blk <= mid;
      endcase
    end
  end

  assign out_data = blk;

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core (NK=4 main, NK=6/8 side instances).
// Reference AES below works on byte arrays straight from FIPS-197.
module tb_aes_iter_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         iv, ir, ov, ordy, bsy;
  logic [127:0] id, od, ik;
  logic         iv6, ir6, ov6, bsy6;
  logic [127:0] id6, od6;
  logic [191:0] ik6;
  logic         iv8, ir8, ov8, bsy8;
  logic [127:0] id8, od8;
  logic [255:0] ik8;

  aes_iter_core #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
    .in_data(id), .in_key(ik), .out_valid(ov),
    .out_ready(ordy), .out_data(od), .busy(bsy)
  );

  aes_iter_core #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6),
    .in_data(id6), .in_key(ik6), .out_valid(ov6),
    .out_ready(1'b1), .out_data(od6), .busy(bsy6)
  );

  aes_iter_core #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .in_data(id8), .in_key(ik8), .out_valid(ov8),
    .out_ready(1'b1), .out_data(od8), .busy(bsy8)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] mul(input logic [7:0] a,
                                     input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                           input logic [255:0] key,
                                           input int nk);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [240];
    logic [7:0] tmp [4];
    logic [7:0] rc, t0, a0, a1, a2, a3;
    logic [127:0] o;
    int nr, nw;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    for (int i = 0; i < 4*nk; i++) w[i] = key[8*(4*nk-1-i) +: 8];
    rc = 8'h01;
    for (int i = nk; i < nw; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % nk == 0) begin
        t0 = tmp[0];
        tmp[0] = tmp[1]; tmp[1] = tmp[2]; tmp[2] = tmp[3]; tmp[3] = t0;
        for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
        tmp[0] = tmp[0] ^ rc;
        rc = mul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[8*(15-i) +: 8] ^ w[i];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr) begin
          s[4*c]   = mul(a0, 8'h02) ^ mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ mul(a1, 8'h02) ^ mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ mul(a2, 8'h02) ^ mul(a3, 8'h03);
          s[4*c+3] = mul(a0, 8'h03) ^ a1 ^ a2 ^ mul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    while (!ir && n < 50) begin @(posedge clk); #1; n++; end
    check("send_ready", ir, 1);
    id = pt; ik = key; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; id = r128(); ik = r128();
  endtask

  task automatic recv(input string tag, input logic [127:0] exp,
                      input int lat);
    int n = 0;
    while (!ov && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, "_lat"}, n, lat);
    check({tag, "_data"}, od, exp);
  endtask

  task automatic run_wide(input string tag, input int nk,
                          input logic [255:0] key, input logic [127:0] pt,
                          input logic [127:0] exp);
    int n = 0;
    logic v;
    if (nk == 6) begin id6 = pt; ik6 = key[191:0]; iv6 = 1'b1; end
    else begin id8 = pt; ik8 = key; iv8 = 1'b1; end
    @(posedge clk); #1;
    iv6 = 1'b0; iv8 = 1'b0;
    v = (nk == 6) ? ov6 : ov8;
    while (!v && n < 40) begin
      @(posedge clk); #1; n++;
      v = (nk == 6) ? ov6 : ov8;
    end
    check({tag, "_lat"}, n, nk + 7);
    check({tag, "_data"}, (nk == 6) ? od6 : od8, exp);
  endtask

  always @(negedge clk) begin
    check("ov_while_busy", {127'b0, ov & bsy}, 128'd0);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] pt, key, exp, pt2, key2, exp2;
    logic [255:0] kw;
    int cnt;
    iv = 0; id = '0; ik = '0; ordy = 1'b1;
    iv6 = 0; id6 = '0; ik6 = '0; iv8 = 0; id8 = '0; ik8 = '0;
    build_sbox();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", ir, 0);
    check("rst_out_valid", ov, 0);
    check("rst_busy", bsy, 0);
    check("rst_out_data", od, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", ir, 1);

    send(128'h3243f6a8885a308d313198a2e0370734,
         128'h2b7e151628aed2a6abf7158809cf4f3c);
    recv("kat1", 128'h3925841d02dc09fbdc118597196a0b32, 11);
    send(128'h00112233445566778899aabbccddeeff,
         128'h000102030405060708090a0b0c0d0e0f);
    recv("kat2", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11);

    repeat (8) begin
      pt = r128(); key = r128();
      exp = aes_ref(pt, {128'h0, key}, 4);
      send(pt, key);
      recv("rand4", exp, 11);
    end

    // backpressure, then back-to-back accept on release
    pt = r128(); key = r128();
    exp = aes_ref(pt, {128'h0, key}, 4);
    send(pt, key);
    ordy = 1'b0;
    recv("bp1", exp, 11);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", od, exp);
      check("bp_hold_valid", ov, 1);
      check("bp_in_ready", ir, 0);
    end
    pt2 = r128(); key2 = r128();
    exp2 = aes_ref(pt2, {128'h0, key2}, 4);
    id = pt2; ik = key2; iv = 1'b1; ordy = 1'b1;
    #1;
    check("bp_ready_follow", ir, 1);
    @(posedge clk); #1;
    iv = 1'b0; id = r128(); ik = r128();
    check("bp_accept_busy", bsy, 1);
    check("bp_accept_ov", ov, 0);
    recv("bp2", exp2, 11);

    // reset in the middle of a block
    send(r128(), r128());
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_ready", ir, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ov", ov, 0);
    check("midrst_busy", bsy, 0);
    check("midrst_data", od, 0);
    cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (ov) cnt++; end
    check("midrst_no_out", cnt, 0);
    pt = r128(); key = r128();
    exp = aes_ref(pt, {128'h0, key}, 4);
    send(pt, key);
    recv("post_midrst", exp, 11);

    // input churn and in_valid pulses while busy
    pt = r128(); key = r128();
    exp = aes_ref(pt, {128'h0, key}, 4);
    send(pt, key);
    for (int i = 0; i < 6; i++) begin
      id = r128(); ik = r128(); iv = 1'b1;
      #1;
      check("busy_not_ready", ir, 0);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    recv("churn", exp, 5);
    cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (ov) cnt++; end
    check("churn_no_extra", cnt, 0);

    // wider keys
    run_wide("kat192", 6,
      {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617},
      128'h00112233445566778899aabbccddeeff,
      128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    run_wide("kat256", 8,
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      128'h00112233445566778899aabbccddeeff,
      128'h8ea2b7ca516745bfeafc49904b496089);
    repeat (3) begin
      pt = r128(); kw = {r128(), r128()};
      run_wide("rand192", 6, kw, pt, aes_ref(pt, kw, 6));
      pt = r128(); kw = {r128(), r128()};
      run_wide("rand256", 8, kw, pt, aes_ref(pt, kw, 8));
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
